// File: rtl/ipm_core_pkg.sv
// rtl/ipm_core_pkg.sv - configuration codes, FSM encoding and status layout for ipm_core_buf
package ipm_core_pkg;

    // Targets of the bridge read/write strobes, selected by configIPi.
    localparam logic [4:0] CONF_INMEM  = 5'h00;
    localparam logic [4:0] CONF_OUTMEM = 5'h01;
    localparam logic [4:0] CONF_STATUS = 5'h02;
    localparam logic [4:0] CONF_SIZE   = 5'h03;
    localparam logic [4:0] CONF_CLEAR  = 5'h04;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // STATUS word: {busy, done, ovf, 13'b0, size (8b), wr_ptr (8b)}.
    localparam int STAT_BUSY      = 31;
    localparam int STAT_DONE      = 30;
    localparam int STAT_OVF       = 29;
    localparam int STAT_SIZE_LSB  = 8;
    localparam int STAT_WRPTR_LSB = 0;

endpackage

// File: rtl/ipm_core_ram.sv
// rtl/ipm_core_ram.sv - simple dual-port synchronous RAM, one write port, one registered read port
//
// Ports:
//   clk_i    write/read clock, rising edge
//   we_i     write enable; wdata_i stored at waddr_i
//   re_i     read enable; rdata_o loads mem[raddr_i] and holds otherwise
// Contents and the read register are deliberately not reset.
module ipm_core_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ipm_core_buf.sv
// rtl/ipm_core_buf.sv - input/output word buffers with a prefix-sum run and done interrupt
//
// Ports:
//   clk_n_Hz       system clock, rising edge
//   rst_async_low  asynchronous active-low reset
//   dataInIPi      write data from the bridge
//   configIPi      target select for read/write strobes (CONF_* codes)
//   readIPi        one-cycle read strobe
//   writeIPi       one-cycle write strobe
//   startIPi       one-cycle start strobe
//   dataOutIPo     read data, valid the cycle after the read strobe, held until next read
//   intIPo         sticky done interrupt
// Build option: IPM_CORE_SATURATE_EN clamps the running sum at all-ones on carry-out.
module ipm_core_buf
    import ipm_core_pkg::*;
#(
    parameter int DATA_WIDTH_IP = 32,
    parameter int CONF_WIDTH    = 5,
    parameter int MEM_DEPTH     = 16,
    parameter int ADDR_W        = 4
) (
    input  logic                     clk_n_Hz,
    input  logic                     rst_async_low,
    input  logic [DATA_WIDTH_IP-1:0] dataInIPi,
    input  logic [CONF_WIDTH-1:0]    configIPi,
    input  logic                     readIPi,
    input  logic                     writeIPi,
    input  logic                     startIPi,
    output logic [DATA_WIDTH_IP-1:0] dataOutIPo,
    output logic                     intIPo
);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, rd_ptr_q, widx_q;
    logic [ADDR_W:0]          size_q, issued_q, size_d;
    logic                     rvalid_q, rsel_q, done_q, ovf_q, int_q;
    logic [DATA_WIDTH_IP-1:0] acc_q, dout_q, acc_d, status;
    logic [DATA_WIDTH_IP-1:0] in_rdata, out_rdata;
    logic [DATA_WIDTH_IP:0]   sum;
    logic                     busy, wr_in, wr_size, wr_clear, rd_out, start_ok, issue, last_wr;

    assign busy     = (state_q == RUN);
    assign wr_in    = writeIPi && (configIPi == CONF_INMEM) && !busy;
    assign wr_size  = writeIPi && (configIPi == CONF_SIZE) && !busy;
    assign wr_clear = writeIPi && (configIPi == CONF_CLEAR);
    assign rd_out   = readIPi && (configIPi == CONF_OUTMEM) && !busy;
    assign start_ok = startIPi && (state_q == IDLE);
    assign last_wr  = rvalid_q && ({1'b0, widx_q} == size_q - (ADDR_W+1)'(1));

    assign size_d = (dataInIPi > DATA_WIDTH_IP'(MEM_DEPTH)) ? (ADDR_W+1)'(MEM_DEPTH)
                                                           : dataInIPi[ADDR_W:0];

    // The input RAM read issued one cycle earlier delivers in[widx_q] now.
    assign sum = {1'b0, acc_q} + {1'b0, in_rdata};
`ifdef IPM_CORE_SATURATE_EN
    // Once clamped, any further nonzero addend carries again, so the clamp persists.
    assign acc_d = sum[DATA_WIDTH_IP] ? '1 : sum[DATA_WIDTH_IP-1:0];
`else
    assign acc_d = sum[DATA_WIDTH_IP-1:0];
`endif

    always_comb begin
        status                                = '0;
        status[STAT_BUSY]                     = busy;
        status[STAT_DONE]                     = done_q;
        status[STAT_OVF]                      = ovf_q;
        status[STAT_SIZE_LSB +: ADDR_W+1]     = size_q;
        status[STAT_WRPTR_LSB +: ADDR_W]      = wr_ptr_q;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (size_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue = (issued_q < size_q);
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
        if (!rst_async_low) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
        if (!rst_async_low) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
            issued_q <= '0;
            widx_q   <= '0;
            rvalid_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            int_q    <= 1'b0;
            rsel_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            if (wr_clear) begin
                wr_ptr_q <= '0;
            end else if (wr_in) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            if (wr_clear) begin
                rd_ptr_q <= '0;
            end else if (rd_out) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            if (wr_size) begin
                size_q <= size_d;
            end

            if (start_ok) begin
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + 1'b1;
            end
            rvalid_q <= issue;
            widx_q   <= issued_q[ADDR_W-1:0];

            if (start_ok) begin
                acc_q <= '0;
            end else if (rvalid_q) begin
                acc_q <= acc_d;
            end

            if (wr_clear) begin
                ovf_q <= 1'b0;
            end else if (rvalid_q && sum[DATA_WIDTH_IP]) begin
                ovf_q <= 1'b1;
            end

            // Completion wins over a same-cycle CLEAR so an interrupt is never lost.
            if (state_q == DONE) begin
                done_q <= 1'b1;
                int_q  <= 1'b1;
            end else if (start_ok || wr_clear) begin
                done_q <= 1'b0;
                int_q  <= 1'b0;
            end

            // OUTMEM data comes straight from the output RAM's read register;
            // every other read lands in dout_q.
            if (readIPi) begin
                if (rd_out) begin
                    rsel_q <= 1'b1;
                end else begin
                    rsel_q <= 1'b0;
                    dout_q <= (configIPi == CONF_STATUS) ? status : '0;
                end
            end
        end
    end

    ipm_core_ram #(.WIDTH(DATA_WIDTH_IP), .DEPTH(MEM_DEPTH), .AW(ADDR_W)) u_in_ram (
        .clk_i   (clk_n_Hz),
        .we_i    (wr_in),
        .waddr_i (wr_ptr_q),
        .wdata_i (dataInIPi),
        .re_i    (issue),
        .raddr_i (issued_q[ADDR_W-1:0]),
        .rdata_o (in_rdata)
    );

    ipm_core_ram #(.WIDTH(DATA_WIDTH_IP), .DEPTH(MEM_DEPTH), .AW(ADDR_W)) u_out_ram (
        .clk_i   (clk_n_Hz),
        .we_i    (rvalid_q),
        .waddr_i (widx_q),
        .wdata_i (acc_d),
        .re_i    (rd_out),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_rdata)
    );

    assign dataOutIPo = rsel_q ? out_rdata : dout_q;
    assign intIPo     = int_q;

endmodule

// File: tb/tb_ipm_core_buf.sv
// tb/tb_ipm_core_buf.sv - self-checking bench for ipm_core_buf
module tb_ipm_core_buf;
    import ipm_core_pkg::*;

    logic        clk_n_Hz = 1'b0;
    logic        rst_async_low;
    logic [31:0] dataInIPi;
    logic [4:0]  configIPi;
    logic        readIPi, writeIPi, startIPi;
    logic [31:0] dataOutIPo;
    logic        intIPo;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_in  [16];
    logic [31:0] model_out [16];
    logic        model_ovf;
    int          m_wp;
    logic [31:0] exp_q [$];

    always #5 clk_n_Hz = ~clk_n_Hz;

    ipm_core_buf dut (
        .clk_n_Hz      (clk_n_Hz),
        .rst_async_low (rst_async_low),
        .dataInIPi     (dataInIPi),
        .configIPi     (configIPi),
        .readIPi       (readIPi),
        .writeIPi      (writeIPi),
        .startIPi      (startIPi),
        .dataOutIPo    (dataOutIPo),
        .intIPo        (intIPo)
    );

    task automatic bus_write(input logic [4:0] conf, input logic [31:0] data);
        @(negedge clk_n_Hz);
        configIPi = conf;
        dataInIPi = data;
        writeIPi  = 1'b1;
        @(negedge clk_n_Hz);
        writeIPi  = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] conf, output logic [31:0] data);
        @(negedge clk_n_Hz);
        configIPi = conf;
        readIPi   = 1'b1;
        @(negedge clk_n_Hz);
        readIPi   = 1'b0;
        data      = dataOutIPo;
    endtask

    task automatic m_write(input logic [31:0] data);
        bus_write(CONF_INMEM, data);
        model_in[m_wp] = data;
        m_wp = (m_wp + 1) % 16;
    endtask

    task automatic m_clear();
        bus_write(CONF_CLEAR, 32'h0);
        m_wp      = 0;
        model_ovf = 1'b0;
    endtask

    function automatic void run_model(input int n);
        logic [32:0] s;
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            s = {1'b0, acc} + {1'b0, model_in[i]};
            if (s[32]) begin
                model_ovf = 1'b1;
`ifdef IPM_CORE_SATURATE_EN
                acc = 32'hFFFF_FFFF;
`else
                acc = s[31:0];
`endif
            end else begin
                acc = s[31:0];
            end
            model_out[i] = acc;
        end
    endfunction

    // Start strobe sampled at edge T0; returns edges after T0 until intIPo is seen high.
    task automatic start_wait(output int cyc);
        @(negedge clk_n_Hz);
        startIPi = 1'b1;
        @(posedge clk_n_Hz);
        #1;
        startIPi = 1'b0;
        cyc = 0;
        while (intIPo !== 1'b1 && cyc < 200) begin
            @(posedge clk_n_Hz);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        tests_run++;
        if (dataOutIPo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_dout got %h expected %h", dataOutIPo, 32'h0);
        end
        tests_run++;
        if (intIPo !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_int got %b expected 0", intIPo);
        end
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status got %h expected %h", got, 32'h0);
        end
    endtask

    task automatic test_prefix();
        logic [31:0] got, exp;
        int cyc;
        m_clear();
        for (int k = 1; k <= 4; k++) m_write(32'(k));
        bus_write(CONF_SIZE, 32'd4);
        run_model(4);
        start_wait(cyc);
        tests_run++;
        if (cyc != 6) begin
            tests_failed++;
            $display("FAIL prefix_latency got %0d expected 6", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL prefix_out[%0d] got %h expected %h", i, got, exp);
            end
        end
        repeat (3) @(negedge clk_n_Hz);
        tests_run++;
        if (dataOutIPo !== 32'd10) begin
            tests_failed++;
            $display("FAIL prefix_hold got %h expected %h", dataOutIPo, 32'd10);
        end
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h4000_0404) begin
            tests_failed++;
            $display("FAIL prefix_status got %h expected %h", got, 32'h4000_0404);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        int cyc;
        m_clear();
        m_write(32'hFFFF_FFFF);
        m_write(32'h2);
        bus_write(CONF_SIZE, 32'd2);
        run_model(2);
        start_wait(cyc);
        tests_run++;
        if (cyc != 4) begin
            tests_failed++;
            $display("FAIL ovf_latency got %0d expected 4", cyc);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL ovf_out[%0d] got %h expected %h", i, got, exp);
            end
        end
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h6000_0202) begin
            tests_failed++;
            $display("FAIL ovf_status got %h expected %h", got, 32'h6000_0202);
        end
    endtask

    task automatic test_size_zero();
        logic [31:0] got, exp;
        int cyc;
        m_clear();
        bus_write(CONF_SIZE, 32'd0);
        start_wait(cyc);
        tests_run++;
        if (cyc != 1) begin
            tests_failed++;
            $display("FAIL zero_latency got %0d expected 1", cyc);
        end
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h4000_0000) begin
            tests_failed++;
            $display("FAIL zero_status got %h expected %h", got, 32'h4000_0000);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL zero_out[%0d] got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_busy();
        logic [31:0] got, exp;
        int n, cyc;
        m_clear();
        for (int k = 1; k <= 12; k++) m_write(32'(k));
        bus_write(CONF_SIZE, 32'd12);
        run_model(12);
        @(negedge clk_n_Hz);
        startIPi = 1'b1;
        @(posedge clk_n_Hz);
        #1;
        startIPi = 1'b0;
        bus_write(CONF_INMEM, 32'd999);
        bus_read(CONF_OUTMEM, got);
        tests_run++;
        if (got !== 32'h0) begin
            tests_failed++;
            $display("FAIL busy_outmem got %h expected %h", got, 32'h0);
        end
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h8000_0C0C) begin
            tests_failed++;
            $display("FAIL busy_status got %h expected %h", got, 32'h8000_0C0C);
        end
        @(negedge clk_n_Hz);
        startIPi = 1'b1;
        @(negedge clk_n_Hz);
        startIPi = 1'b0;
        bus_write(CONF_CLEAR, 32'h0);
        m_wp = 0;
        n = 0;
        while (intIPo !== 1'b1 && n < 50) begin
            @(posedge clk_n_Hz);
            #1;
            n++;
        end
        tests_run++;
        if (n != 5) begin
            tests_failed++;
            $display("FAIL busy_int_delay got %0d expected 5", n);
        end
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h4000_0C00) begin
            tests_failed++;
            $display("FAIL busy_status_after got %h expected %h", got, 32'h4000_0C00);
        end
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL busy_out[%0d] got %h expected %h", i, got, exp);
            end
        end
        bus_write(CONF_CLEAR, 32'h0);
        tests_run++;
        if (intIPo !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_int got %b expected 0", intIPo);
        end
        repeat (10) @(negedge clk_n_Hz);
        tests_run++;
        if (intIPo !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_int_stays got %b expected 0", intIPo);
        end
        start_wait(cyc);
        tests_run++;
        if (cyc != 14) begin
            tests_failed++;
            $display("FAIL rerun_latency got %0d expected 14", cyc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got, exp;
        int cyc;
        m_clear();
        for (int k = 0; k < 17; k++) m_write(32'h100 + 32'(k));
        bus_write(CONF_SIZE, 32'd40);
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h0000_1001) begin
            tests_failed++;
            $display("FAIL wrap_status got %h expected %h", got, 32'h0000_1001);
        end
        run_model(16);
        start_wait(cyc);
        tests_run++;
        if (cyc != 18) begin
            tests_failed++;
            $display("FAIL wrap_latency got %0d expected 18", cyc);
        end
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL wrap_out[%0d] got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        int cyc;
        m_clear();
        m_write(32'd5);
        m_write(32'd6);
        bus_write(CONF_SIZE, 32'd3);
        @(negedge clk_n_Hz);
        configIPi = CONF_INMEM;
        dataInIPi = 32'd7;
        writeIPi  = 1'b1;
        startIPi  = 1'b1;
        @(posedge clk_n_Hz);
        #1;
        writeIPi  = 1'b0;
        startIPi  = 1'b0;
        model_in[m_wp] = 32'd7;
        m_wp = m_wp + 1;
        run_model(3);
        cyc = 0;
        while (intIPo !== 1'b1 && cyc < 200) begin
            @(posedge clk_n_Hz);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc != 5) begin
            tests_failed++;
            $display("FAIL b2b_latency got %0d expected 5", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL b2b_out[%0d] got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] got, exp;
        int cyc;
        m_clear();
        for (int k = 1; k <= 8; k++) m_write(32'(k * 3));
        bus_write(CONF_SIZE, 32'd8);
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h0000_0808) begin
            tests_failed++;
            $display("FAIL pre_reset_status got %h expected %h", got, 32'h0000_0808);
        end
        @(negedge clk_n_Hz);
        startIPi = 1'b1;
        @(posedge clk_n_Hz);
        #1;
        startIPi = 1'b0;
        repeat (4) @(posedge clk_n_Hz);
        #2;
        rst_async_low = 1'b0;
        #1;
        tests_run++;
        if (dataOutIPo !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_dout got %h expected %h", dataOutIPo, 32'h0);
        end
        tests_run++;
        if (intIPo !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_int got %b expected 0", intIPo);
        end
        @(negedge clk_n_Hz);
        rst_async_low = 1'b1;
        m_wp      = 0;
        model_ovf = 1'b0;
        bus_read(CONF_STATUS, got);
        tests_run++;
        if (got !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_status got %h expected %h", got, 32'h0);
        end
        for (int k = 1; k <= 8; k++) m_write(32'(k * 3));
        bus_write(CONF_SIZE, 32'd8);
        run_model(8);
        start_wait(cyc);
        tests_run++;
        if (cyc != 10) begin
            tests_failed++;
            $display("FAIL midrst_rerun_latency got %0d expected 10", cyc);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(model_out[i]);
            bus_read(CONF_OUTMEM, got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL midrst_out[%0d] got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_async_low = 1'b0;
        dataInIPi     = '0;
        configIPi     = '0;
        readIPi       = 1'b0;
        writeIPi      = 1'b0;
        startIPi      = 1'b0;
        m_wp          = 0;
        model_ovf     = 1'b0;
        repeat (3) @(negedge clk_n_Hz);
        rst_async_low = 1'b1;

        test_reset();
        test_prefix();
        test_overflow();
        test_size_zero();
        test_busy();
        test_wrap();
        test_back_to_back();
        test_reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
